uart_tx_sched: RTL
==================

# uart_tx_sched

TX-side scheduler for the UART FIFO path. It sits between the 16-entry byte FIFO (`fifo_uart`) and the UART serializer. It pops one byte at a time when the FIFO is non-empty and the serializer is idle, then launches the serializer with a start/busy handshake and enforces an inter-frame guard gap. It also collects FIFO error pulses into sticky status bits, drives a maskable interrupt, and counts transmitted frames.

## Interface
- `GAP`, 2, idle guard cycles inserted after each frame (0 allowed)
- `START_TO`, 8, max cycles to wait for `tx_busy` after `tx_start` before declaring a start timeout
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous active-high reset
- `en`  in  1  scheduler enable; low = finish current frame, then hold in IDLE
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_dout`  in  8  FIFO read data; valid the cycle after a pop is sampled
- `fifo_overrun`  in  1  FIFO overrun pulse
- `fifo_underrun`  in  1  FIFO underrun pulse
- `fifo_thres_trig`  in  1  FIFO level ≥ threshold (level signal)
- `fifo_pop`  out  1  one-cycle pop request to FIFO (`pop_in`)
- `tx_busy`  in  1  serializer busy, high for the whole frame
- `tx_start`  out  1  one-cycle start pulse to serializer
- `tx_data`  out  8  byte to serializer, held stable from `tx_start` until the frame ends
- `ie`  in  4  interrupt enables: [0] threshold, [1] overrun, [2] underrun, [3] start timeout
- `clr`  in  1  one-cycle clear of all sticky bits
- `sticky`  out  3  {timeout, underrun, overrun} sticky flags
- `irq`  out  1  registered OR of enabled sources
- `frame_cnt`  out  16  frames launched since reset, wraps at 0xFFFF→0
- `active`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, POP, START, WAIT_DONE, GAP.
- IDLE: if `en & !fifo_empty & !tx_busy`, assert `fifo_pop` for 1 cycle and go to POP. Otherwise stay.
- POP: latch `fifo_dout` into `tx_data`, assert `tx_start` for 1 cycle, clear the timeout counter, and go to START.
- START: wait for `tx_busy`=1, then go to WAIT_DONE and increment `frame_cnt`. If `START_TO` cycles elapse without `tx_busy`, set `sticky[2]` and go to IDLE. In this case the byte is dropped and not counted.
- WAIT_DONE: on `tx_busy`=0, go to GAP if `GAP`>0, else go to IDLE.
- GAP: count `GAP` cycles, then go to IDLE.
- `en` is sampled only in IDLE. Deasserting it mid-frame does not abort the frame.
- Sticky bits: `sticky[0]` is set by `fifo_overrun` and `sticky[1]` by `fifo_underrun`. They hold until `clr`. If a set and `clr` occur in the same cycle, set wins.
- `irq` = (`ie[0]` & `fifo_thres_trig`) | (`ie[1]` & `sticky[0]`) | (`ie[2]` & `sticky[1]`) | (`ie[3]` & `sticky[2]`), registered one cycle.
- The block never pops when `fifo_empty`=1, so it cannot itself cause an underrun.
- Counter widths: the timeout counter is sized to hold `START_TO`. The gap counter is sized to hold `GAP`, with a minimum of 1 bit.

## Timing
- Reset values: state=IDLE; `fifo_pop`, `tx_start`, `irq`, `active`, `sticky` = 0; `tx_data`=0x00; `frame_cnt`=0.
- A reset mid-frame returns to IDLE immediately. A byte already popped is lost.
- All outputs are registered.
- Latency from the cycle `fifo_empty` falls (with `en`=1, idle) to `fifo_pop` high: 1 cycle.
- `fifo_pop` to `tx_start`: 1 cycle.
- `tx_start` to `tx_busy` expected within `START_TO` cycles.
- Minimum spacing between consecutive `tx_start` pulses: frame length + `GAP` + 3 cycles.
- `frame_cnt` updates the cycle after `tx_busy` is first seen high.
- The `irq` source-to-output delay is 1 cycle. Clearing via `clr` drops `irq` 2 cycles later, unless the threshold source is still active.

## Test plan
- Reset and basic send: FIFO holds 0xA5, `en`=1, serializer model busy 10 cycles after start → `fifo_pop` 1 pulse, `tx_start` 1 pulse next cycle, `tx_data`=0xA5 stable through busy, `frame_cnt`=1, back to IDLE after 2 gap cycles.
- Burst drain: preload 16 bytes 0x00..0x0F → exactly 16 pops and 16 starts, bytes delivered in order, `frame_cnt`=16, no pop while `fifo_empty`=1, start-to-start spacing equals busy + 5 cycles.
- Enable drop mid-frame: deassert `en` during WAIT_DONE with 3 bytes remaining → current frame completes, no further `fifo_pop`. Reassert `en` → the remaining 3 are sent.
- Start timeout: serializer never raises `tx_busy` → after 8 cycles `sticky[2]`=1, `frame_cnt` unchanged, `irq`=1 with `ie[3]`=1 and 0 with `ie`=0. `clr` clears it.
- Sticky and irq: pulse `fifo_overrun` with `ie`=4'b0010 → `sticky[0]`=1 and `irq`=1 next cycle. `clr` coincident with a new `fifo_underrun` → `sticky[1]`=1 and `sticky[0]`=0. `fifo_thres_trig` high with `ie[0]`=1 → `irq` follows it.
- Async reset mid-operation: assert `rst` during GAP and during START → all outputs return to their reset values without a clock edge, and the next frame starts cleanly after release.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Signal bundle between the UART TX scheduler, its byte FIFO and the serializer.
// The scheduler takes the master side; the FIFO/serializer/CPU environment takes the slave side.
interface uart_tx_sched_if;
    logic        en;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_overrun;
    logic        fifo_underrun;
    logic        fifo_thres_trig;
    logic        fifo_pop;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [3:0]  ie;
    logic        clr;
    logic [2:0]  sticky;
    logic        irq;
    logic [15:0] frame_cnt;
    logic        active;

    modport master (
        input  en, fifo_empty, fifo_dout, fifo_overrun, fifo_underrun, fifo_thres_trig,
               tx_busy, ie, clr,
        output fifo_pop, tx_start, tx_data, sticky, irq, frame_cnt, active
    );

    modport slave (
        output en, fifo_empty, fifo_dout, fifo_overrun, fifo_underrun, fifo_thres_trig,
               tx_busy, ie, clr,
        input  fifo_pop, tx_start, tx_data, sticky, irq, frame_cnt, active
    );
endinterface

// File: rtl/uart_tx_sched.sv
// TX scheduler: pops bytes from the UART FIFO, launches the serializer, enforces an
// inter-frame guard gap, and keeps sticky error flags, a maskable irq and a frame counter.
module uart_tx_sched #(
    parameter int unsigned GAP      = 2,
    parameter int unsigned START_TO = 8
) (
    input logic             clk,
    input logic             rst,
    uart_tx_sched_if.master bus
);

    localparam int unsigned ToW     = (START_TO < 2) ? 1 : $clog2(START_TO + 1);
    localparam int unsigned GapW    = (GAP < 2) ? 1 : $clog2(GAP + 1);
    localparam int unsigned ToLast  = (START_TO > 0) ? START_TO - 1 : 0;
    localparam int unsigned GapLast = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StStart,
        StWaitDone,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic              fifo_pop_q, fifo_pop_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [ToW-1:0]    to_cnt_q, to_cnt_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [2:0]        sticky_q, sticky_d;
    logic              irq_q, irq_d;
    logic              active_q, active_d;
    logic              timeout;

    always_comb begin
        state_d     = state_q;
        fifo_pop_d  = 1'b0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        to_cnt_d    = to_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;
        timeout     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.en && !bus.fifo_empty && !bus.tx_busy) begin
                    fifo_pop_d = 1'b1;
                    state_d    = StPop;
                end
            end
            StPop: begin
                tx_data_d  = bus.fifo_dout;
                tx_start_d = 1'b1;
                to_cnt_d   = '0;
                state_d    = StStart;
            end
            StStart: begin
                if (bus.tx_busy) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = StWaitDone;
                end else if (to_cnt_q == ToW'(ToLast)) begin
                    // Serializer never acknowledged: the byte is dropped and not counted.
                    timeout = 1'b1;
                    state_d = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + ToW'(1);
                end
            end
            StWaitDone: begin
                if (!bus.tx_busy) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP > 0) ? StGap : StIdle;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapW'(GapLast)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A new set event in the same cycle as clr keeps the bit set.
    always_comb begin
        sticky_d[0] = bus.fifo_overrun  | (sticky_q[0] & ~bus.clr);
        sticky_d[1] = bus.fifo_underrun | (sticky_q[1] & ~bus.clr);
        sticky_d[2] = timeout           | (sticky_q[2] & ~bus.clr);

        irq_d = (bus.ie[0] & bus.fifo_thres_trig) |
                (bus.ie[1] & sticky_q[0]) |
                (bus.ie[2] & sticky_q[1]) |
                (bus.ie[3] & sticky_q[2]);

        active_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            fifo_pop_q  <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= 16'd0;
            sticky_q    <= 3'b000;
            irq_q       <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fifo_pop_q  <= fifo_pop_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            to_cnt_q    <= to_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            sticky_q    <= sticky_d;
            irq_q       <= irq_d;
            active_q    <= active_d;
        end
    end

    assign bus.fifo_pop  = fifo_pop_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.sticky    = sticky_q;
    assign bus.irq       = irq_q;
    assign bus.active    = active_q;

endmodule
